// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//
// Purpose:
//   Shares one single-port, synchronous-read video RAM between the video
//   scan-out fetch path and the Z80 CPU. Video fetches normally win a slot so
//   display timing is kept. The CPU uses the slots video leaves free. A wait
//   counter forces a CPU slot once the CPU has waited MAX_WAIT cycles. A
//   one-entry deferral buffer holds the video fetch that loses to such a
//   forced slot.
//
// Parameters:
//   AW        RAM / CPU byte address width
//   VAW       video fetch address width (vid_base supplies the top AW-VAW bits)
//   MAX_WAIT  CPU request cycles without a grant before a forced CPU slot
//
// Ports:
//   clk, n_reset          system clock, asynchronous active-low reset
//   vid_base              screen page, concatenated above vid_addr (no carry)
//   vid_req, vid_addr     one-cycle fetch strobe and its address
//   vid_data, vid_valid   fetched byte (held) and its one-cycle update pulse
//   vid_overrun           sticky flag: a video fetch was dropped
//   cpu_req, cpu_we       level request (held until cpu_ack), 1 = write
//   cpu_addr, cpu_wdata   CPU address and write data, stable while cpu_req
//   cpu_rdata, cpu_ack    read data and one-cycle completion pulse
//   n_wait                active-low Z80 WAIT
//   ram_addr/we/wdata     registered RAM command
//   ram_rdata             RAM read data, valid one clock after the address edge
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int AW       = 16,
  parameter int VAW      = 14,
  parameter int MAX_WAIT = 6
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [AW-VAW-1:0] vid_base,
  input  logic              vid_req,
  input  logic [VAW-1:0]    vid_addr,
  output logic [7:0]        vid_data,
  output logic              vid_valid,
  output logic              vid_overrun,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [AW-1:0]     cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              n_wait,
  output logic [AW-1:0]     ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_LIMIT = WCW'(MAX_WAIT);

  // Owner of the RAM slot decided at the current edge.
  typedef enum logic [1:0] {
    SLOT_IDLE,
    SLOT_VID,
    SLOT_CPU
  } slot_t;

  // What the data phase must do with ram_rdata as an access moves down the
  // two-stage tag pipeline.
  typedef enum logic [1:0] {
    TAG_IDLE,
    TAG_VID,
    TAG_CPU_RD,
    TAG_CPU_WR
  } tag_t;

  // RAM command registers
  logic [AW-1:0]  ramAddr_q,    ramAddr_d;
  logic           ramWe_q,      ramWe_d;
  logic [7:0]     ramWdata_q,   ramWdata_d;

  // Video return path
  logic [7:0]     vidData_q,    vidData_d;
  logic           vidValid_q,   vidValid_d;
  logic           vidOverrun_q, vidOverrun_d;

  // CPU return path and bookkeeping
  logic [7:0]     cpuRdata_q,   cpuRdata_d;
  logic           cpuAck_q,     cpuAck_d;
  logic           cpuBusy_q,    cpuBusy_d;
  logic [WCW-1:0] waitCnt_q,    waitCnt_d;

  // One-entry deferral buffer for a video fetch that lost to a forced CPU slot
  logic           deferVld_q,   deferVld_d;
  logic [AW-1:0]  deferAddr_q,  deferAddr_d;

  // Tag pipeline: stage 0 is the slot issued at E0, stage 1 the slot of E0-1
  tag_t           tag0_q,       tag0_d;
  tag_t           tag1_q,       tag1_d;

  logic           cpuPending;
  logic           forcedCpu;
  slot_t          slot;
  logic [AW-1:0]  vidFullAddr;

  assign vidFullAddr = {vid_base, vid_addr};

  // Slot arbitration. A CPU request counts as pending only while no CPU
  // access is in flight and the ack cycle has passed. This way a request that
  // is still held high during its own ack is not taken as a second access.
  always_comb begin
    cpuPending = cpu_req && !cpuBusy_q && !cpuAck_q;
    forcedCpu  = cpuPending && (waitCnt_q == WAIT_LIMIT);
    slot       = SLOT_IDLE;
    if (forcedCpu) begin
      slot = SLOT_CPU;
    end else if (deferVld_q || vid_req) begin
      slot = SLOT_VID;
    end else if (cpuPending) begin
      slot = SLOT_CPU;
    end
  end

  // Slot issue and deferral buffer management. An idle slot keeps the
  // address and only lowers the write enable.
  always_comb begin
    ramAddr_d    = ramAddr_q;
    ramWe_d      = 1'b0;
    ramWdata_d   = ramWdata_q;
    tag0_d       = TAG_IDLE;
    deferVld_d   = deferVld_q;
    deferAddr_d  = deferAddr_q;
    vidOverrun_d = vidOverrun_q;

    unique case (slot)
      SLOT_VID: begin
        tag0_d = TAG_VID;
        if (deferVld_q) begin
          // Serve the buffered fetch. A new request in the same cycle
          // refills the buffer, so no fetch is lost.
          ramAddr_d  = deferAddr_q;
          deferVld_d = vid_req;
          if (vid_req) begin
            deferAddr_d = vidFullAddr;
          end
        end else begin
          ramAddr_d = vidFullAddr;
        end
      end
      SLOT_CPU: begin
        ramAddr_d  = cpu_addr;
        ramWe_d    = cpu_we;
        ramWdata_d = cpu_wdata;
        if (cpu_we) begin
          tag0_d = TAG_CPU_WR;
        end else begin
          tag0_d = TAG_CPU_RD;
        end
        // Only a forced CPU slot can coincide with vid_req. Park the fetch,
        // or drop it and flag overrun when the buffer is already occupied.
        if (vid_req) begin
          if (deferVld_q) begin
            vidOverrun_d = 1'b1;
          end else begin
            deferVld_d  = 1'b1;
            deferAddr_d = vidFullAddr;
          end
        end
      end
      default: begin
      end
    endcase
  end

  // Data phase and CPU bookkeeping. A write has no data phase, so it acks
  // from stage 0 (E0+1). A read acks from stage 1 (E0+2) together with the
  // captured data.
  always_comb begin
    tag1_d     = tag0_q;
    cpuAck_d   = (tag0_q == TAG_CPU_WR) || (tag1_q == TAG_CPU_RD);
    cpuRdata_d = cpuRdata_q;
    vidData_d  = vidData_q;
    vidValid_d = 1'b0;
    if (tag1_q == TAG_CPU_RD) begin
      cpuRdata_d = ram_rdata;
    end
    if (tag1_q == TAG_VID) begin
      vidData_d  = ram_rdata;
      vidValid_d = 1'b1;
    end

    cpuBusy_d = cpuBusy_q;
    if (cpuAck_d) begin
      cpuBusy_d = 1'b0;
    end
    if (slot == SLOT_CPU) begin
      cpuBusy_d = 1'b1;
    end

    // The wait counter measures only slots the CPU actually lost.
    waitCnt_d = waitCnt_q;
    if (!cpu_req || (slot == SLOT_CPU)) begin
      waitCnt_d = '0;
    end else if (cpuPending && (waitCnt_q != WAIT_LIMIT)) begin
      waitCnt_d = waitCnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      ramAddr_q    <= '0;
      ramWe_q      <= 1'b0;
      ramWdata_q   <= '0;
      vidData_q    <= '0;
      vidValid_q   <= 1'b0;
      vidOverrun_q <= 1'b0;
      cpuRdata_q   <= '0;
      cpuAck_q     <= 1'b0;
      cpuBusy_q    <= 1'b0;
      waitCnt_q    <= '0;
      deferVld_q   <= 1'b0;
      deferAddr_q  <= '0;
      tag0_q       <= TAG_IDLE;
      tag1_q       <= TAG_IDLE;
    end else begin
      ramAddr_q    <= ramAddr_d;
      ramWe_q      <= ramWe_d;
      ramWdata_q   <= ramWdata_d;
      vidData_q    <= vidData_d;
      vidValid_q   <= vidValid_d;
      vidOverrun_q <= vidOverrun_d;
      cpuRdata_q   <= cpuRdata_d;
      cpuAck_q     <= cpuAck_d;
      cpuBusy_q    <= cpuBusy_d;
      waitCnt_q    <= waitCnt_d;
      deferVld_q   <= deferVld_d;
      deferAddr_q  <= deferAddr_d;
      tag0_q       <= tag0_d;
      tag1_q       <= tag1_d;
    end
  end

  assign ram_addr    = ramAddr_q;
  assign ram_we      = ramWe_q;
  assign ram_wdata   = ramWdata_q;
  assign vid_data    = vidData_q;
  assign vid_valid   = vidValid_q;
  assign vid_overrun = vidOverrun_q;
  assign cpu_rdata   = cpuRdata_q;
  assign cpu_ack     = cpuAck_q;
  // WAIT must follow cpu_req combinationally, including during reset.
  assign n_wait      = !(cpu_req && !cpuAck_q);

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//
// Purpose:
//   Testbench for vram_arbiter. It runs directed scenarios and then a
//   randomized phase. A synchronous-read RAM model sits on the RAM port.
//   Expected values come from a shadow of the RAM contents and from the
//   latency and priority rules of the arbiter.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int MAX_WAIT = 6;

  logic        clk;
  logic        nReset;
  logic [1:0]  vidBase;
  logic        vidReq;
  logic [13:0] vidAddr;
  logic [7:0]  vidData;
  logic        vidValid;
  logic        vidOverrun;
  logic        cpuReq;
  logic        cpuWe;
  logic [15:0] cpuAddr;
  logic [7:0]  cpuWdata;
  logic [7:0]  cpuRdata;
  logic        cpuAck;
  logic        nWait;
  logic [15:0] ramAddr;
  logic        ramWe;
  logic [7:0]  ramWdata;
  logic [7:0]  ramRdata;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Bytes written by the CPU. Addresses not in here still hold the initial
  // pattern.
  logic [7:0] shadow [logic [15:0]];

  typedef struct {
    logic [15:0] addr;
    int          sampled;
  } vidExpT;
  vidExpT vidQ[$];

  bit prevVid    = 1'b0;
  bit cpuActive  = 1'b0;
  int cpuStart   = 0;
  int lastAckCyc = -100;

  vram_arbiter #(.AW(16), .VAW(14), .MAX_WAIT(MAX_WAIT)) dut (
    .clk        (clk),
    .n_reset    (nReset),
    .vid_base   (vidBase),
    .vid_req    (vidReq),
    .vid_addr   (vidAddr),
    .vid_data   (vidData),
    .vid_valid  (vidValid),
    .vid_overrun(vidOverrun),
    .cpu_req    (cpuReq),
    .cpu_we     (cpuWe),
    .cpu_addr   (cpuAddr),
    .cpu_wdata  (cpuWdata),
    .cpu_rdata  (cpuRdata),
    .cpu_ack    (cpuAck),
    .n_wait     (nWait),
    .ram_addr   (ramAddr),
    .ram_we     (ramWe),
    .ram_wdata  (ramWdata),
    .ram_rdata  (ramRdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] initPattern(input logic [15:0] a);
    if (a == 16'hC123) return 8'h5A;
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  function automatic logic [7:0] expectedByte(input logic [15:0] a);
    if (shadow.exists(a)) return shadow[a];
    return initPattern(a);
  endfunction

  // Synchronous-read RAM, read-before-write. It is loaded with the pattern
  // while reset is held.
  logic [7:0] mem [0:65535];
  always @(posedge clk) begin
    if (!nReset) begin
      for (int i = 0; i < 65536; i++) mem[i] <= initPattern(16'(i));
    end else if (ramWe) begin
      mem[ramAddr] <= ramWdata;
    end
    ramRdata <= mem[ramAddr];
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // One CPU access with no video traffic. expLat is the number of edges from
  // the drive point to the ack.
  task automatic cpuAccess(input string tag, input logic we, input logic [15:0] addr,
                           input logic [7:0] wdata, input int expLat);
    int lat;
    bit seen;
    bit waitOk;
    logic [7:0] expData;
    expData  = expectedByte(addr);
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAddr  = addr;
    cpuWdata = wdata;
    lat      = 0;
    seen     = 1'b0;
    waitOk   = 1'b1;
    #1;
    if (nWait !== 1'b0) waitOk = 1'b0;
    while (!seen && lat < 20) begin
      tick();
      lat++;
      if (cpuAck === 1'b1) seen = 1'b1;
      else if (nWait !== 1'b0) waitOk = 1'b0;
    end
    checkOutput({tag, "_ack_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, "_nwait_low_while_waiting"}, 32'(waitOk), 32'd1);
    checkOutput({tag, "_nwait_high_at_ack"}, 32'(nWait), 32'd1);
    if (!we) checkOutput({tag, "_rdata"}, 32'(cpuRdata), 32'(expData));
    else shadow[addr] = wdata;
    cpuReq = 1'b0;
    tick();
  endtask

  // One cycle of the randomized phase: drive new requests (if allowed), step
  // the clock, then score what came back.
  task automatic applyStimulus(input bit allowNew);
    int lat;
    vidExpT e;
    if (allowNew && !prevVid && $urandom_range(0, 1) == 1) begin
      vidReq  = 1'b1;
      vidBase = 2'b11;
      vidAddr = 14'($urandom);
      e.addr    = {2'b11, vidAddr};
      e.sampled = cyc + 1;
      vidQ.push_back(e);
      prevVid = 1'b1;
    end else begin
      vidReq  = 1'b0;
      prevVid = 1'b0;
    end
    if (allowNew && !cpuActive && cyc > lastAckCyc && $urandom_range(0, 3) == 0) begin
      cpuActive = 1'b1;
      cpuReq    = 1'b1;
      cpuWe     = 1'($urandom_range(0, 1));
      cpuAddr   = 16'h4000 + 16'($urandom_range(0, 15));
      cpuWdata  = 8'($urandom);
      cpuStart  = cyc;
    end

    tick();

    if (vidValid === 1'b1) begin
      checkOutput("rnd_vid_expected", 32'(vidQ.size() != 0), 32'd1);
      if (vidQ.size() != 0) begin
        e   = vidQ.pop_front();
        lat = cyc - e.sampled;
        checkOutput("rnd_vid_data", 32'(vidData), 32'(expectedByte(e.addr)));
        checkOutput("rnd_vid_latency_2or3", 32'(lat == 2 || lat == 3), 32'd1);
      end
    end
    if (vidQ.size() != 0 && (cyc - vidQ[0].sampled) > 3) begin
      checkOutput("rnd_vid_lost_age", 32'(cyc - vidQ[0].sampled), 32'd3);
      void'(vidQ.pop_front());
    end

    if (!cpuActive) begin
      checkOutput("rnd_cpu_no_spurious_ack", 32'(cpuAck), 32'd0);
    end else if (cpuAck === 1'b1) begin
      lat = cyc - cpuStart;
      if (cpuWe) begin
        checkOutput("rnd_cpu_wr_latency_ok", 32'(lat >= 2 && lat <= MAX_WAIT + 2), 32'd1);
        shadow[cpuAddr] = cpuWdata;
      end else begin
        checkOutput("rnd_cpu_rd_latency_ok", 32'(lat >= 3 && lat <= MAX_WAIT + 3), 32'd1);
        checkOutput("rnd_cpu_rdata", 32'(cpuRdata), 32'(expectedByte(cpuAddr)));
      end
      cpuActive  = 1'b0;
      cpuReq     = 1'b0;
      lastAckCyc = cyc;
    end else if (cyc - cpuStart > 4 * MAX_WAIT) begin
      checkOutput("rnd_cpu_ack_timeout", 32'(cpuAck), 32'd1);
      cpuActive  = 1'b0;
      cpuReq     = 1'b0;
      lastAckCyc = cyc;
    end
  endtask

  logic [1:0]  vBaseTab [4] = '{2'b11, 2'b01, 2'b00, 2'b11};
  logic [13:0] vAddrTab [4] = '{14'h0123, 14'h0ABC, 14'h3FFF, 14'h3FFF};
  logic [15:0] vExpTab  [4] = '{16'hC123, 16'h4ABC, 16'h3FFF, 16'hFFFF};

  initial begin
    int lat;
    int grantEdge;
    int firstOv;
    logic [15:0] starveAddr;

    nReset   = 1'b0;
    vidBase  = 2'b00;
    vidReq   = 1'b0;
    vidAddr  = '0;
    cpuReq   = 1'b1;
    cpuWe    = 1'b0;
    cpuAddr  = 16'h0010;
    cpuWdata = 8'h00;

    // Reset with a CPU read already requested
    repeat (4) tick();
    checkOutput("rst_ram_addr",    32'(ramAddr),    32'd0);
    checkOutput("rst_ram_we",      32'(ramWe),      32'd0);
    checkOutput("rst_ram_wdata",   32'(ramWdata),   32'd0);
    checkOutput("rst_vid_data",    32'(vidData),    32'd0);
    checkOutput("rst_vid_valid",   32'(vidValid),   32'd0);
    checkOutput("rst_vid_overrun", 32'(vidOverrun), 32'd0);
    checkOutput("rst_cpu_rdata",   32'(cpuRdata),   32'd0);
    checkOutput("rst_cpu_ack",     32'(cpuAck),     32'd0);
    checkOutput("rst_n_wait",      32'(nWait),      32'd0);
    nReset = 1'b1;
    lat = 0;
    while (cpuAck !== 1'b1 && lat < 10) begin
      tick();
      lat++;
    end
    checkOutput("rst_first_ack_within_3", 32'(lat <= 3), 32'd1);
    checkOutput("rst_first_rdata", 32'(cpuRdata), 32'(initPattern(16'h0010)));
    cpuReq = 1'b0;
    repeat (2) tick();

    // Video only, one fetch every 8 clocks, including page/address wrap cases
    for (int i = 0; i < 4; i++) begin
      vidBase = vBaseTab[i];
      vidAddr = vAddrTab[i];
      vidReq  = 1'b1;
      tick();
      checkOutput("vid_ram_addr", 32'(ramAddr), 32'(vExpTab[i]));
      checkOutput("vid_ram_we", 32'(ramWe), 32'd0);
      vidReq = 1'b0;
      tick();
      checkOutput("vid_valid_early", 32'(vidValid), 32'd0);
      tick();
      checkOutput("vid_valid_pulse", 32'(vidValid), 32'd1);
      checkOutput("vid_data", 32'(vidData), 32'(expectedByte(vExpTab[i])));
      repeat (5) tick();
      checkOutput("vid_valid_after", 32'(vidValid), 32'd0);
      checkOutput("vid_data_held", 32'(vidData), 32'(expectedByte(vExpTab[i])));
    end
    checkOutput("vid_c123_is_5a", 32'(expectedByte(16'hC123) == 8'h5A), 32'd1);

    // CPU write then read of 0x4000
    cpuAccess("cpu_wr", 1'b1, 16'h4000, 8'hA5, 2);
    cpuAccess("cpu_rd", 1'b0, 16'h4000, 8'h00, 3);
    checkOutput("cpu_rd_a5", 32'(cpuRdata), 32'h0000_00A5);

    // Collision: video wins the first slot, CPU takes the next
    vidBase = 2'b11;
    vidAddr = 14'h0456;
    vidReq  = 1'b1;
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = 16'h4000;
    tick();
    checkOutput("col_first_slot_vid", 32'(ramAddr), 32'h0000_C456);
    vidReq = 1'b0;
    tick();
    checkOutput("col_second_slot_cpu", 32'(ramAddr), 32'h0000_4000);
    tick();
    checkOutput("col_vid_valid", 32'(vidValid), 32'd1);
    checkOutput("col_vid_data", 32'(vidData), 32'(expectedByte(16'hC456)));
    tick();
    checkOutput("col_cpu_ack", 32'(cpuAck), 32'd1);
    checkOutput("col_cpu_rdata", 32'(cpuRdata), 32'h0000_00A5);
    cpuReq = 1'b0;
    repeat (3) tick();

    // Starvation: continuous video, CPU gets the 7th slot (after 6 waits)
    starveAddr = 16'h2222;
    grantEdge  = 0;
    cpuReq     = 1'b1;
    cpuWe      = 1'b0;
    cpuAddr    = starveAddr;
    vidBase    = 2'b11;
    vidReq     = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      vidAddr = 14'h1000 + 14'(k);
      if (k == 9) vidReq = 1'b0;
      tick();
      if (ramAddr === starveAddr && grantEdge == 0) grantEdge = k;
      if (k == 8) checkOutput("stv_deferred_slot", 32'(ramAddr), 32'(16'hC000 + 16'h1007));
      if (k == 9) begin
        checkOutput("stv_refilled_slot", 32'(ramAddr), 32'(16'hC000 + 16'h1008));
        checkOutput("stv_cpu_ack", 32'(cpuAck), 32'd1);
        checkOutput("stv_cpu_rdata", 32'(cpuRdata), 32'(expectedByte(starveAddr)));
        checkOutput("stv_no_vid_at_cpu_data", 32'(vidValid), 32'd0);
        cpuReq = 1'b0;
      end
      if (k == 10) begin
        checkOutput("stv_deferred_valid_lat3", 32'(vidValid), 32'd1);
        checkOutput("stv_deferred_data", 32'(vidData), 32'(expectedByte(16'hD007)));
      end
    end
    checkOutput("stv_grant_edge", 32'(grantEdge), 32'd7);
    checkOutput("stv_no_overrun", 32'(vidOverrun), 32'd0);
    repeat (3) tick();

    // Randomized traffic, video never back-to-back so nothing may be dropped
    for (int c = 0; c < 3000; c++) applyStimulus(1'b1);
    for (int c = 0; c < 30; c++) applyStimulus(1'b0);
    checkOutput("rnd_vid_queue_drained", 32'(vidQ.size()), 32'd0);
    checkOutput("rnd_cpu_idle", 32'(cpuActive), 32'd0);
    checkOutput("rnd_no_overrun", 32'(vidOverrun), 32'd0);

    // Overrun: second forced CPU slot meets a full deferral buffer
    firstOv = 0;
    cpuReq  = 1'b1;
    cpuWe   = 1'b0;
    cpuAddr = 16'h1234;
    vidBase = 2'b11;
    vidReq  = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      vidAddr = 14'h2000 + 14'(k);
      tick();
      if (vidOverrun === 1'b1 && firstOv == 0) firstOv = k;
    end
    vidReq = 1'b0;
    cpuReq = 1'b0;
    checkOutput("ovr_first_edge", 32'(firstOv), 32'd17);
    repeat (10) tick();
    checkOutput("ovr_sticky", 32'(vidOverrun), 32'd1);
    nReset = 1'b0;
    #1;
    checkOutput("ovr_cleared_by_reset", 32'(vidOverrun), 32'd0);
    repeat (2) tick();
    nReset = 1'b1;
    shadow.delete();
    tick();
    checkOutput("ovr_stays_clear", 32'(vidOverrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
